sram_write_scheduler: RTL and testbench

- Upstream stage of the 4-port 32-bit SRAM.
- Accepts write requests from two independent producers (channel A, channel B) via valid/ready. Each channel is buffered in its own FIFO.
- Each cycle it drives the SRAM's two write ports (W_A, W_B) from the FIFO heads.
- Same-address collisions are serialised so the SRAM never sees two writes to one address in one cycle.

---
 rtl/sram_write_scheduler.sv | 218 +++++++++++++++++++++
 tb/tb_sram_write_scheduler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sram_write_scheduler
// Description : Buffers write requests from two producers in per-channel
//               FIFOs and drives the two SRAM write ports from the FIFO
//               heads. Same-address pairs are split over two cycles
//               (A first, then B) so the SRAM never sees a write collision.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_write_scheduler #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  Clk_In,
   input  logic                  Reset_In,
   input  logic                  Ch_A_Valid_In,
   output logic                  Ch_A_Ready_Out,
   input  logic [ADDR_WIDTH-1:0] Ch_A_Address_In,
   input  logic [DATA_WIDTH-1:0] Ch_A_Data_In,
   input  logic                  Ch_B_Valid_In,
   output logic                  Ch_B_Ready_Out,
   input  logic [ADDR_WIDTH-1:0] Ch_B_Address_In,
   input  logic [DATA_WIDTH-1:0] Ch_B_Data_In,
   output logic [DATA_WIDTH-1:0] Port_W_A_Data_Out,
   output logic [ADDR_WIDTH-1:0] Port_W_A_Address_Out,
   output logic                  Port_W_A_Write_Enable_Out,
   output logic [DATA_WIDTH-1:0] Port_W_B_Data_Out,
   output logic [ADDR_WIDTH-1:0] Port_W_B_Address_Out,
   output logic                  Port_W_B_Write_Enable_Out,
   output logic                  Idle_Out,
   output logic [CNT_WIDTH-1:0]  Collision_Count_Out
);

   // Pointer width is exact because the depth is a power of two, so the
   // pointers wrap modulo FIFO_DEPTH on their own.
   localparam int c_ptr_w = $clog2(FIFO_DEPTH);
   localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;
   localparam logic [c_cnt_w-1:0]   c_full_cnt = c_cnt_w'(FIFO_DEPTH);
   localparam logic [CNT_WIDTH-1:0] c_cnt_max  = {CNT_WIDTH{1'b1}};

   // Collision state machine encoding
   localparam logic [0:0] c_ST_IDLE   = 1'b0;
   localparam logic [0:0] c_ST_HOLD_B = 1'b1;

   // Channel-indexed views of the two request interfaces (0 = A, 1 = B)
   logic [1:0]            w_in_valid;
   logic [ADDR_WIDTH-1:0] w_in_addr [2];
   logic [DATA_WIDTH-1:0] w_in_data [2];
   logic [1:0]            w_ready;
   logic [1:0]            w_push;
   logic [1:0]            w_pop;
   logic [1:0]            w_empty;
   logic [ADDR_WIDTH-1:0] w_head_addr [2];
   logic [DATA_WIDTH-1:0] w_head_data [2];

   logic [0:0]            r_state;
   logic [0:0]            w_state_nxt;
   logic                  w_collision;

   logic                  r_we_a;
   logic                  r_we_b;
   logic [ADDR_WIDTH-1:0] r_addr_a;
   logic [ADDR_WIDTH-1:0] r_addr_b;
   logic [DATA_WIDTH-1:0] r_data_a;
   logic [DATA_WIDTH-1:0] r_data_b;
   logic [CNT_WIDTH-1:0]  r_coll_cnt;

   assign w_in_valid   = {Ch_B_Valid_In, Ch_A_Valid_In};
   assign w_in_addr[0] = Ch_A_Address_In;
   assign w_in_addr[1] = Ch_B_Address_In;
   assign w_in_data[0] = Ch_A_Data_In;
   assign w_in_data[1] = Ch_B_Data_In;

   // --------------------------------------------------------------------
   // Per-channel FIFO
   // --------------------------------------------------------------------
   for (genvar ch = 0; ch < 2; ch++) begin : g_fifo
      logic [ADDR_WIDTH-1:0] r_mem_addr [FIFO_DEPTH];
      logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
      logic [c_ptr_w-1:0]    r_wr_ptr;
      logic [c_ptr_w-1:0]    r_rd_ptr;
      logic [c_cnt_w-1:0]    r_count;

      // Ready is held low during reset so nothing is accepted while flushing
      assign w_ready[ch]     = !Reset_In && (r_count != c_full_cnt);
      assign w_push[ch]      = w_in_valid[ch] && w_ready[ch];
      assign w_empty[ch]     = (r_count == '0);
      assign w_head_addr[ch] = r_mem_addr[r_rd_ptr];
      assign w_head_data[ch] = r_mem_data[r_rd_ptr];

      // Storage array; contents are don't-care once the pointers are flushed
      always_ff @(posedge Clk_In) begin
         if (w_push[ch]) begin
            r_mem_addr[r_wr_ptr] <= w_in_addr[ch];
            r_mem_data[r_wr_ptr] <= w_in_data[ch];
         end
      end

      // Pointer and occupancy bookkeeping
      always_ff @(posedge Clk_In or posedge Reset_In) begin
         if (Reset_In) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_push[ch]) begin
               r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop[ch]) begin
               r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push[ch], w_pop[ch]})
               2'b10:   r_count <= r_count + 1'b1;
               2'b01:   r_count <= r_count - 1'b1;
               default: r_count <= r_count;
            endcase
         end
      end
   end

   assign Ch_A_Ready_Out = w_ready[0];
   assign Ch_B_Ready_Out = w_ready[1];

   // --------------------------------------------------------------------
   // Issue decision: which heads pop this cycle and the next state
   // --------------------------------------------------------------------
   always_comb begin
      w_pop       = 2'b00;
      w_collision = 1'b0;
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE: begin
            if (!w_empty[0] && !w_empty[1] && (w_head_addr[0] == w_head_addr[1])) begin
               // Same address: A goes now, B is deferred one cycle so B's
               // data is the value the SRAM ends up holding.
               w_pop[0]    = 1'b1;
               w_collision = 1'b1;
               w_state_nxt = c_ST_HOLD_B;
            end else begin
               w_pop[0] = !w_empty[0];
               w_pop[1] = !w_empty[1];
            end
         end
         c_ST_HOLD_B: begin
            // The deferred B entry is still at the head of its FIFO; the
            // next A entry may join it only if it targets another address.
            w_pop[1]    = !w_empty[1];
            w_pop[0]    = !w_empty[0] && (w_head_addr[0] != w_head_addr[1]);
            w_state_nxt = c_ST_IDLE;
         end
         default: begin
            w_state_nxt = c_ST_IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge Clk_In or posedge Reset_In) begin
      if (Reset_In) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Write port A output register; address/data hold while idle
   always_ff @(posedge Clk_In or posedge Reset_In) begin
      if (Reset_In) begin
         r_we_a   <= 1'b0;
         r_addr_a <= '0;
         r_data_a <= '0;
      end else begin
         r_we_a <= w_pop[0];
         if (w_pop[0]) begin
            r_addr_a <= w_head_addr[0];
            r_data_a <= w_head_data[0];
         end
      end
   end

   // Write port B output register; address/data hold while idle
   always_ff @(posedge Clk_In or posedge Reset_In) begin
      if (Reset_In) begin
         r_we_b   <= 1'b0;
         r_addr_b <= '0;
         r_data_b <= '0;
      end else begin
         r_we_b <= w_pop[1];
         if (w_pop[1]) begin
            r_addr_b <= w_head_addr[1];
            r_data_b <= w_head_data[1];
         end
      end
   end

   // Saturating count of same-address serialisations
   always_ff @(posedge Clk_In or posedge Reset_In) begin
      if (Reset_In) begin
         r_coll_cnt <= '0;
      end else if (w_collision && (r_coll_cnt != c_cnt_max)) begin
         r_coll_cnt <= r_coll_cnt + 1'b1;
      end
   end

   assign Port_W_A_Data_Out         = r_data_a;
   assign Port_W_A_Address_Out      = r_addr_a;
   assign Port_W_A_Write_Enable_Out = r_we_a;
   assign Port_W_B_Data_Out         = r_data_b;
   assign Port_W_B_Address_Out      = r_addr_b;
   assign Port_W_B_Write_Enable_Out = r_we_b;
   assign Collision_Count_Out       = r_coll_cnt;
   assign Idle_Out = w_empty[0] && w_empty[1] && !r_we_a && !r_we_b &&
                     (r_state == c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sram_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_write_scheduler
// Description : Directed self-checking bench for sram_write_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_write_scheduler;

   logic        clk;
   logic        rst;
   logic        va, vb;
   logic [7:0]  aa, ab;
   logic [31:0] da, db;
   logic        rdy_a, rdy_b;
   logic [31:0] wa_d, wb_d;
   logic [7:0]  wa_a, wb_a;
   logic        wa_we, wb_we;
   logic        idle;
   logic [1:0]  ccnt;

   int n_checks = 0;
   int n_errors = 0;

   sram_write_scheduler #(
      .DATA_WIDTH(32), .ADDR_WIDTH(8), .FIFO_DEPTH(4), .CNT_WIDTH(2)
   ) dut (
      .Clk_In(clk), .Reset_In(rst),
      .Ch_A_Valid_In(va), .Ch_A_Ready_Out(rdy_a),
      .Ch_A_Address_In(aa), .Ch_A_Data_In(da),
      .Ch_B_Valid_In(vb), .Ch_B_Ready_Out(rdy_b),
      .Ch_B_Address_In(ab), .Ch_B_Data_In(db),
      .Port_W_A_Data_Out(wa_d), .Port_W_A_Address_Out(wa_a),
      .Port_W_A_Write_Enable_Out(wa_we),
      .Port_W_B_Data_Out(wb_d), .Port_W_B_Address_Out(wb_a),
      .Port_W_B_Write_Enable_Out(wb_we),
      .Idle_Out(idle), .Collision_Count_Out(ccnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: records every issued write and models the SRAM contents
   logic [31:0] q_a[$];
   logic [31:0] q_b[$];
   logic [31:0] mem [256];

   always @(negedge clk) begin
      if (!rst) begin
         if (wa_we) begin
            q_a.push_back(wa_d);
            mem[wa_a] = wa_d;
         end
         if (wb_we) begin
            q_b.push_back(wb_d);
            mem[wb_a] = wb_d;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      va = 1'b0; vb = 1'b0; aa = '0; ab = '0; da = '0; db = '0;
   endtask

   // Synchronous-looking reset pulse of one cycle, issued from a negedge
   task automatic pulse_reset();
      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      q_a.delete();
      q_b.delete();
   endtask

   typedef struct packed {
      logic        va;
      logic [7:0]  aa;
      logic [31:0] da;
      logic        vb;
      logic [7:0]  ab;
      logic [31:0] db;
      logic        we_a;
      logic [7:0]  ea;
      logic [31:0] eda;
      logic        we_b;
      logic [7:0]  eb;
      logic [31:0] edb;
      logic [1:0]  cnt;
      logic        idle;
   } vec_t;

   vec_t tbl [12];

   initial begin
      // inputs applied before an edge | outputs expected after that edge
      tbl[0]  = '{1'b1, 8'h10, 32'hDEADBEEF, 1'b1, 8'h20, 32'h12345678,
                  1'b0, 8'h00, 32'h00000000, 1'b0, 8'h00, 32'h00000000, 2'd0, 1'b0};
      tbl[1]  = '{1'b0, 8'h00, 32'h0, 1'b0, 8'h00, 32'h0,
                  1'b1, 8'h10, 32'hDEADBEEF, 1'b1, 8'h20, 32'h12345678, 2'd0, 1'b0};
      tbl[2]  = '{1'b0, 8'h00, 32'h0, 1'b0, 8'h00, 32'h0,
                  1'b0, 8'h10, 32'hDEADBEEF, 1'b0, 8'h20, 32'h12345678, 2'd0, 1'b1};
      tbl[3]  = '{1'b1, 8'h33, 32'h11111111, 1'b1, 8'h33, 32'h22222222,
                  1'b0, 8'h10, 32'hDEADBEEF, 1'b0, 8'h20, 32'h12345678, 2'd0, 1'b0};
      tbl[4]  = '{1'b0, 8'h00, 32'h0, 1'b0, 8'h00, 32'h0,
                  1'b1, 8'h33, 32'h11111111, 1'b0, 8'h20, 32'h12345678, 2'd1, 1'b0};
      tbl[5]  = '{1'b0, 8'h00, 32'h0, 1'b0, 8'h00, 32'h0,
                  1'b0, 8'h33, 32'h11111111, 1'b1, 8'h33, 32'h22222222, 2'd1, 1'b0};
      tbl[6]  = '{1'b0, 8'h00, 32'h0, 1'b0, 8'h00, 32'h0,
                  1'b0, 8'h33, 32'h11111111, 1'b0, 8'h33, 32'h22222222, 2'd1, 1'b1};
      tbl[7]  = '{1'b1, 8'h40, 32'hAAAA0001, 1'b0, 8'h00, 32'h0,
                  1'b0, 8'h33, 32'h11111111, 1'b0, 8'h33, 32'h22222222, 2'd1, 1'b0};
      tbl[8]  = '{1'b0, 8'h00, 32'h0, 1'b0, 8'h00, 32'h0,
                  1'b1, 8'h40, 32'hAAAA0001, 1'b0, 8'h33, 32'h22222222, 2'd1, 1'b0};
      tbl[9]  = '{1'b0, 8'h00, 32'h0, 1'b1, 8'h50, 32'hBBBB0001,
                  1'b0, 8'h40, 32'hAAAA0001, 1'b0, 8'h33, 32'h22222222, 2'd1, 1'b0};
      tbl[10] = '{1'b0, 8'h00, 32'h0, 1'b0, 8'h00, 32'h0,
                  1'b0, 8'h40, 32'hAAAA0001, 1'b1, 8'h50, 32'hBBBB0001, 2'd1, 1'b0};
      tbl[11] = '{1'b0, 8'h00, 32'h0, 1'b0, 8'h00, 32'h0,
                  1'b0, 8'h40, 32'hAAAA0001, 1'b0, 8'h50, 32'hBBBB0001, 2'd1, 1'b1};

      for (int i = 0; i < 256; i++) mem[i] = '0;
      idle_inputs();

      // ---------------- reset with valid held high ----------------
      rst = 1'b1;
      va = 1'b1; vb = 1'b1; aa = 8'h05; ab = 8'h06; da = 32'h0BAD0001; db = 32'h0BAD0002;
      repeat (2) begin
         @(negedge clk);
         chk("rst_ready_a", {31'b0, rdy_a}, 32'd0);
         chk("rst_ready_b", {31'b0, rdy_b}, 32'd0);
         chk("rst_we_a", {31'b0, wa_we}, 32'd0);
         chk("rst_we_b", {31'b0, wb_we}, 32'd0);
         chk("rst_count", {30'b0, ccnt}, 32'd0);
         chk("rst_idle", {31'b0, idle}, 32'd1);
      end
      rst = 1'b0;
      idle_inputs();
      @(negedge clk);
      chk("post_rst_ready_a", {31'b0, rdy_a}, 32'd1);
      chk("post_rst_ready_b", {31'b0, rdy_b}, 32'd1);
      chk("post_rst_idle", {31'b0, idle}, 32'd1);
      repeat (3) @(negedge clk);
      #1;
      chk("post_rst_no_writes", q_a.size() + q_b.size(), 32'd0);

      // ---------------- table: disjoint, collision, single-channel ----------------
      for (int i = 0; i < 12; i++) begin
         va = tbl[i].va; aa = tbl[i].aa; da = tbl[i].da;
         vb = tbl[i].vb; ab = tbl[i].ab; db = tbl[i].db;
         @(negedge clk);
         chk($sformatf("v%0d_we_a", i), {31'b0, wa_we}, {31'b0, tbl[i].we_a});
         chk($sformatf("v%0d_addr_a", i), {24'b0, wa_a}, {24'b0, tbl[i].ea});
         chk($sformatf("v%0d_data_a", i), wa_d, tbl[i].eda);
         chk($sformatf("v%0d_we_b", i), {31'b0, wb_we}, {31'b0, tbl[i].we_b});
         chk($sformatf("v%0d_addr_b", i), {24'b0, wb_a}, {24'b0, tbl[i].eb});
         chk($sformatf("v%0d_data_b", i), wb_d, tbl[i].edb);
         chk($sformatf("v%0d_count", i), {30'b0, ccnt}, {30'b0, tbl[i].cnt});
         chk($sformatf("v%0d_idle", i), {31'b0, idle}, {31'b0, tbl[i].idle});
      end
      idle_inputs();
      #1;
      chk("sram_0x33_last_writer_b", mem[8'h33], 32'h22222222);

      // ---------------- backpressure: same-address stream fills FIFO A ----------------
      pulse_reset();
      for (int k = 1; k <= 7; k++) begin
         va = 1'b1; aa = 8'h77; da = 32'hA0000000 + k;
         vb = (k <= 4); ab = 8'h77; db = 32'hB0000000 + k;
         @(negedge clk);
         chk($sformatf("bp_ready_a_%0d", k), {31'b0, rdy_a}, (k == 7) ? 32'd0 : 32'd1);
      end
      // offered while full: must be dropped by the handshake
      va = 1'b1; vb = 1'b0; da = 32'hA0000008;
      @(negedge clk);
      idle_inputs();
      chk("bp_ready_a_reopen", {31'b0, rdy_a}, 32'd1);
      for (int c = 0; c < 50; c++) begin
         if (idle) break;
         @(negedge clk);
      end
      @(negedge clk);
      #1;
      chk("bp_a_write_count", q_a.size(), 32'd7);
      chk("bp_b_write_count", q_b.size(), 32'd4);
      for (int i = 0; i < 7; i++)
         if (i < q_a.size()) chk($sformatf("bp_a_order_%0d", i), q_a[i], 32'hA0000001 + i);
      for (int i = 0; i < 4; i++)
         if (i < q_b.size()) chk($sformatf("bp_b_order_%0d", i), q_b[i], 32'hB0000001 + i);
      chk("bp_sram_0x77", mem[8'h77], 32'hA0000007);

      // ---------------- asynchronous reset mid-stream ----------------
      pulse_reset();
      for (int k = 1; k <= 4; k++) begin
         va = 1'b1; aa = 8'h88; da = 32'hC0000000 + k;
         vb = 1'b1; ab = 8'h88; db = 32'hD0000000 + k;
         @(negedge clk);
      end
      idle_inputs();
      chk("mid_we_a_before_reset", {31'b0, wa_we}, 32'd1);
      chk("mid_b_backlog_not_ready_idle", {31'b0, idle}, 32'd0);
      #2 rst = 1'b1;
      #1;
      chk("mid_we_a_drop", {31'b0, wa_we}, 32'd0);
      chk("mid_we_b_drop", {31'b0, wb_we}, 32'd0);
      chk("mid_ready_b", {31'b0, rdy_b}, 32'd0);
      chk("mid_idle", {31'b0, idle}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      q_a.delete();
      q_b.delete();
      repeat (10) @(negedge clk);
      #1;
      chk("mid_no_writes_after", q_a.size() + q_b.size(), 32'd0);
      chk("mid_idle_after", {31'b0, idle}, 32'd1);

      // ---------------- collision counter saturation ----------------
      pulse_reset();
      for (int k = 1; k <= 5; k++) begin
         va = 1'b1; aa = 8'h90 + k[7:0]; da = 32'hE0000000 + k;
         vb = 1'b1; ab = 8'h90 + k[7:0]; db = 32'hF0000000 + k;
         @(negedge clk);
         idle_inputs();
         repeat (3) @(negedge clk);
         chk($sformatf("sat_count_%0d", k), {30'b0, ccnt}, (k >= 3) ? 32'd3 : k);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
